// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
// Streaming LEGv8 instruction encoder. Accepts one symbolic instruction per
// req handshake, packs it into the 32-bit machine word and presents it on an
// instruction-memory write port at an auto-incrementing byte address.
//
// Optional feature macro: ENC_RANGE_CHECK_EN
//   defined   : immediates outside their field width (and MOV hw values that
//               need a 64-bit register while sf=0) are rejected and set err.
//   undefined : immediates are truncated to the field width; only illegal
//               ops set err.
//
// Handshakes (valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holding valid keeps its payload stable until the transfer.
//   req_ready = !wr_valid || wr_ready, so the single output register can be
//   refilled on the same edge that its current word is written.

module legv8_instr_encoder #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // request side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        op,
    input  logic [1:0]        fn,
    input  logic              sf,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [25:0]       imm,
    input  logic [1:0]        hw,
    input  logic [3:0]        cond,
    // address pointer control
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    // instruction-memory write port
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [15:0]       wr_count,
    output logic              err
);

    // Op classes
    localparam logic [3:0] OP_ADD_IMM = 4'd0;
    localparam logic [3:0] OP_ADD_REG = 4'd1;
    localparam logic [3:0] OP_LOGIC   = 4'd2;
    localparam logic [3:0] OP_MOV     = 4'd3;
    localparam logic [3:0] OP_B       = 4'd4;
    localparam logic [3:0] OP_CB      = 4'd5;
    localparam logic [3:0] OP_BCOND   = 4'd6;
    localparam logic [3:0] OP_BR      = 4'd7;
    localparam logic [3:0] OP_MEM     = 4'd8;
    localparam logic [3:0] OP_MUL     = 4'd9;

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    // State
    logic              valid_q,  valid_d;
    logic [31:0]       data_q,   data_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W-1:0] ptr_q,    ptr_d;
    logic [15:0]       count_q,  count_d;
    logic              err_q,    err_d;

    // Datapath helpers
    logic [31:0]       enc_word;
    logic              op_illegal;
    logic              range_fail;
    logic              accept;
    logic              wr_done;
    logic              reject;
    logic              load_word;
    logic [ADDR_W-1:0] ptr_next_word;
    logic [ADDR_W-1:0] ptr_load_val;
    logic              addr_in_lsb_unused;

    // The two low address bits are forced to zero, so they never reach logic.
    assign addr_in_lsb_unused = ^addr_in[1:0];
    assign ptr_load_val       = {addr_in[ADDR_W-1:2], 2'b00};

    // Handshake terms
    assign req_ready = !valid_q || wr_ready;
    assign accept    = req_valid && req_ready;
    assign wr_done   = valid_q && wr_ready;
    assign reject    = accept && (op_illegal || range_fail);
    assign load_word = accept && !reject;

    // Address for a newly accepted word: if the pending word completes on the
    // same edge, the new word goes to the slot after it (keeps base, +4, +8
    // ordering at full throughput).
    assign ptr_next_word = wr_done ? (ptr_q + WORD_BYTES) : ptr_q;

    // Pack the symbolic fields into the machine word for the current op
    always_comb begin
        enc_word   = 32'd0;
        op_illegal = 1'b0;
        case (op)
            OP_ADD_IMM: enc_word = {sf, fn[1], fn[0], 6'b100010, 1'b0,
                                    imm[11:0], rn, rd};
            OP_ADD_REG: enc_word = {sf, fn[1], fn[0], 5'b01011, 3'b000,
                                    rm, 6'b000000, rn, rd};
            // fn is the opc: 00 AND, 01 ORR, 10 EOR, 11 ANDS
            OP_LOGIC:   enc_word = {sf, fn, 5'b01010, 3'b000,
                                    rm, 6'b000000, rn, rd};
            OP_MOV:     enc_word = {sf, 1'b1, fn[0], 6'b100101, hw,
                                    imm[15:0], rd};
            OP_B:       enc_word = {fn[0], 5'b00101, imm[25:0]};
            OP_CB:      enc_word = {sf, 6'b011010, fn[0], imm[18:0], rd};
            OP_BCOND:   enc_word = {8'b01010100, imm[18:0], 1'b0, cond};
            OP_BR:      enc_word = 32'hD61F_0000 | {22'd0, rn, 5'd0};
            OP_MEM:     enc_word = {8'b11111000, 1'b0, fn[0], 1'b0,
                                    imm[8:0], 2'b00, rn, rd};
            OP_MUL:     enc_word = {sf, 10'b0011011000, rm, 1'b0,
                                    5'b11111, rn, rd};
            default: begin
                enc_word   = 32'd0;
                op_illegal = 1'b1;
            end
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // True when every bit above the field's sign bit repeats the sign bit
    function automatic logic imm_signed_fits(input logic [25:0] v,
                                             input int unsigned w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if ((i >= w) && (v[i] != v[w-1])) ok = 1'b0;
        end
        return ok;
    endfunction

    // True when every bit above the field width is zero
    function automatic logic imm_unsigned_fits(input logic [25:0] v,
                                               input int unsigned w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if ((i >= w) && v[i]) ok = 1'b0;
        end
        return ok;
    endfunction

    // Reject immediates that do not fit, and 64-bit-only MOV shifts with sf=0
    always_comb begin
        range_fail = 1'b0;
        case (op)
            OP_ADD_IMM: range_fail = !imm_unsigned_fits(imm, 12);
            OP_MOV:     range_fail = !imm_unsigned_fits(imm, 16) ||
                                     (!sf && hw[1]);
            OP_B:       range_fail = !imm_signed_fits(imm, 26);
            OP_CB:      range_fail = !imm_signed_fits(imm, 19);
            OP_BCOND:   range_fail = !imm_signed_fits(imm, 19);
            OP_MEM:     range_fail = !imm_signed_fits(imm, 9);
            default:    range_fail = 1'b0;
        endcase
    end
`else
    // Out-of-range immediates are truncated by the field slicing above
    assign range_fail = 1'b0;
`endif

    // Next-state for the output register, address pointer, counter and err
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;

        // Output register: completion frees it, acceptance refills it
        if (wr_done) begin
            valid_d = 1'b0;
        end
        if (load_word) begin
            valid_d = 1'b1;
            data_d  = enc_word;
            addr_d  = ptr_next_word;
        end

        // Pointer: advance on completion; an explicit load wins
        if (wr_done) begin
            ptr_d   = ptr_q + WORD_BYTES;
            count_d = count_q + 16'd1;
        end
        if (addr_load) begin
            ptr_d = ptr_load_val;
        end

        // Sticky error for rejected requests
        if (reject) begin
            err_d = 1'b1;
        end
    end

    // State registers, asynchronously cleared; a pending word is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 32'd0;
            addr_q  <= '0;
            ptr_q   <= '0;
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Outputs come straight from the registers
    assign wr_valid = valid_q;
    assign wr_data  = data_q;
    assign wr_addr  = addr_q;
    assign wr_count = count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder
// Directed vectors with hand-computed machine words. Expected writes are
// pushed to exp_q as {addr, data}; a negedge monitor pops one per completed
// write. Honours ENC_RANGE_CHECK_EN for the out-of-range immediate case.

module tb_legv8_instr_encoder;

    localparam int ADDR_W = 64;

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        op = '0;
    logic [1:0]        fn = '0;
    logic              sf = 1'b0;
    logic [4:0]        rd = '0, rn = '0, rm = '0;
    logic [25:0]       imm = '0;
    logic [1:0]        hw = '0;
    logic [3:0]        cond = '0;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_in = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b1;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [15:0]       wr_count;
    logic              err;

    legv8_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .fn        (fn),
        .sf        (sf),
        .rd        (rd),
        .rn        (rn),
        .rm        (rm),
        .imm       (imm),
        .hw        (hw),
        .cond      (cond),
        .addr_load (addr_load),
        .addr_in   (addr_in),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_count  (wr_count),
        .err       (err)
    );

    // ---------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W-1:0]  exp_ptr = '0;
    int                 exp_count = 0;

    task automatic check_val(input string tag, input logic [63:0] act,
                             input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data);
        exp_q.push_back({exp_ptr, data});
        exp_ptr   = exp_ptr + 4;
        exp_count = exp_count + 1;
    endtask

    // Every completed write must match the next expected {addr, data}
    always @(negedge clk) begin
        logic [ADDR_W+31:0] e;
        if (rst_n && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {32'd0, wr_data}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", wr_addr, e[ADDR_W+31:32]);
                check_val("wr_data", {32'd0, wr_data}, {32'd0, e[31:0]});
            end
        end
    end

    // ---------------------------------------------------------------
    // Driver tasks (called between clock edges)
    // ---------------------------------------------------------------
    task automatic set_req(input logic [3:0] o, input logic [1:0] f,
                           input logic s, input logic [4:0] d,
                           input logic [4:0] n, input logic [4:0] m,
                           input logic [25:0] i, input logic [1:0] h,
                           input logic [3:0] c);
        op = o; fn = f; sf = s; rd = d; rn = n; rm = m;
        imm = i; hw = h; cond = c;
    endtask

    // Hold req_valid until the request is accepted, bounded
    task automatic send(input logic [3:0] o, input logic [1:0] f,
                        input logic s, input logic [4:0] d,
                        input logic [4:0] n, input logic [4:0] m,
                        input logic [25:0] i, input logic [1:0] h,
                        input logic [3:0] c);
        bit done;
        done = 1'b0;
        set_req(o, f, s, d, n, m, i, h, c);
        req_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        if (!done) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        logic [31:0] held_data;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
        check_val("rst_wr_addr", wr_addr, 64'd0);
        check_val("rst_wr_data", {32'd0, wr_data}, 64'd0);
        check_val("rst_wr_count", {48'd0, wr_count}, 64'd0);
        check_val("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check_val("rst_req_ready", {63'd0, req_ready}, 64'd1);

        // ADD X1,X2,#5
        push_exp(32'h9100_1441);
        send(4'd0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd0, 26'd5, 2'd0, 4'd0);
        idle(2);
        check_val("add_count", {48'd0, wr_count}, 64'(exp_count));
        check_val("add_err", {63'd0, err}, 64'd0);

        // Pointer load with unaligned base, then BR X30
        addr_load = 1'b1;
        addr_in   = 64'h1003;
        idle(1);
        addr_load = 1'b0;
        exp_ptr   = 64'h1000;
        push_exp(32'hD61F_03C0);
        send(4'd7, 2'b00, 1'b0, 5'd0, 5'd30, 5'd0, 26'd0, 2'd0, 4'd0);
        idle(2);

        // LDUR X3,[X4,#8] stalled three cycles, then B.NE -1
        wr_ready = 1'b0;
        push_exp(32'hF840_8083);
        push_exp(32'h54FF_FFE1);
        send(4'd8, 2'b01, 1'b0, 5'd3, 5'd4, 5'd0, 26'd8, 2'd0, 4'd0);
        held_data = 32'hF840_8083;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("stall_valid", {63'd0, wr_valid}, 64'd1);
            check_val("stall_ready", {63'd0, req_ready}, 64'd0);
            check_val("stall_data", {32'd0, wr_data}, {32'd0, held_data});
            check_val("stall_addr", wr_addr, 64'h1004);
        end
        wr_ready = 1'b1;
        send(4'd6, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF, 2'd0, 4'd1);
        idle(2);

        // MUL X0,X1,X2 back-to-back
        set_req(4'd9, 2'b00, 1'b1, 5'd0, 5'd1, 5'd2, 26'd0, 2'd0, 4'd0);
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_exp(32'h9B02_7C20);
            #1;
            check_val("stream_req_ready", {63'd0, req_ready}, 64'd1);
            @(posedge clk);
            #1;
            check_val("stream_wr_valid", {63'd0, wr_valid}, 64'd1);
        end
        req_valid = 1'b0;
        idle(2);
        check_val("stream_count", {48'd0, wr_count}, 64'(exp_count));

        // Other encodings
        push_exp(32'h1100_1441);  // ADD W1,W2,#5
        send(4'd0, 2'b00, 1'b0, 5'd1, 5'd2, 5'd0, 26'd5, 2'd0, 4'd0);
        push_exp(32'hCB07_00C5);  // SUB X5,X6,X7
        send(4'd1, 2'b10, 1'b1, 5'd5, 5'd6, 5'd7, 26'd0, 2'd0, 4'd0);
        push_exp(32'h4A03_0041);  // EOR W1,W2,W3
        send(4'd2, 2'b10, 1'b0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 4'd0);
        push_exp(32'hF2B7_DDE9);  // MOVK X9,#0xBEEF,LSL 16
        send(4'd3, 2'b01, 1'b1, 5'd9, 5'd0, 5'd0, 26'hBEEF, 2'd1, 4'd0);
        push_exp(32'h97FF_FFFE);  // BL -2
        send(4'd4, 2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFE, 2'd0, 4'd0);
        push_exp(32'hB500_0083);  // CBNZ X3,+4
        send(4'd5, 2'b01, 1'b1, 5'd3, 5'd0, 5'd0, 26'd4, 2'd0, 4'd0);
        idle(2);
        check_val("enc_count", {48'd0, wr_count}, 64'(exp_count));
        check_val("enc_err", {63'd0, err}, 64'd0);

        // Illegal op: accepted, not written, err set
        send(4'd12, 2'b00, 1'b1, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 4'd0);
        idle(2);
        check_val("illegal_count", {48'd0, wr_count}, 64'(exp_count));
        check_val("illegal_err", {63'd0, err}, 64'd1);

        // Out-of-range ADD immediate
`ifdef ENC_RANGE_CHECK_EN
        send(4'd0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd0, 26'h1000, 2'd0, 4'd0);
`else
        push_exp(32'h9100_0041);
        send(4'd0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd0, 26'h1000, 2'd0, 4'd0);
`endif
        idle(2);
        check_val("range_count", {48'd0, wr_count}, 64'(exp_count));
        check_val("range_err", {63'd0, err}, 64'd1);

        // Reset while a word is pending and stalled
        wr_ready = 1'b0;
        send(4'd0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd0, 26'd5, 2'd0, 4'd0);
        @(negedge clk);
        check_val("pre_rst_valid", {63'd0, wr_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", {63'd0, wr_valid}, 64'd0);
        check_val("mid_rst_count", {48'd0, wr_count}, 64'd0);
        check_val("mid_rst_addr", wr_addr, 64'd0);
        check_val("mid_rst_data", {32'd0, wr_data}, 64'd0);
        check_val("mid_rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        wr_ready  = 1'b1;
        exp_ptr   = '0;
        exp_count = 0;
        push_exp(32'h9100_1441);
        send(4'd0, 2'b00, 1'b1, 5'd1, 5'd2, 5'd0, 26'd5, 2'd0, 4'd0);
        idle(2);
        check_val("post_rst_count", {48'd0, wr_count}, 64'd1);

        check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/legv8_instr_encoder.md
# legv8_instr_encoder

Streaming LEGv8 instruction encoder, the inverse of the control unit's decode path. It accepts one symbolic instruction per handshake (op class, function bits, register fields, immediate) and packs it into the 32-bit machine word the control unit decodes. It writes that word to instruction memory at an auto-incrementing byte address. It sits between the test/boot program loader and the instruction-memory write port.

## Interface
- ADDR_W, 64, width of the instruction-memory byte address
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  encoder can accept a request this cycle
- op  in  4  class: 0 ADD/SUB imm, 1 ADD/SUB reg, 2 logic reg, 3 MOVZ/MOVK, 4 B/BL, 5 CBZ/CBNZ, 6 B.cond, 7 BR, 8 LDUR/STUR, 9 MUL; 10–15 illegal
- fn  in  2  variant: op0/1 {sub, setflags}; op2 00 AND/01 ORR/10 EOR/11 ANDS; op3 fn[0]=MOVK; op4 fn[0]=BL; op5 fn[0]=CBNZ; op8 fn[0]=LDUR
- sf  in  1  64-bit (1) / 32-bit (0) operation; ignored for ops 4, 6, 7, 8
- rd, rn, rm  in  5 each  register fields; rd is Rt for ops 5 and 8
- imm  in  26  immediate; signed for ops 4, 5, 6, 8; unsigned otherwise
- hw  in  2  MOV shift field
- cond  in  4  B.cond condition
- addr_load  in  1  load the write address from addr_in
- addr_in  in  ADDR_W  new base byte address; bits [1:0] are ignored and forced to 0
- wr_valid  out  1  instruction word pending on the write port
- wr_ready  in  1  memory accepts the word
- wr_addr  out  ADDR_W  byte address of the pending word
- wr_data  out  32  encoded instruction
- wr_count  out  16  words written since reset; wraps
- err  out  1  sticky: a request was rejected

## Operation
- Encodings (imm field placement):
  - op0: {sf, fn[1], fn[0], 100010, 0, imm[11:0], rn, rd}
  - op1: {sf, fn[1], fn[0], 01011, 000, rm, 000000, rn, rd}
  - op2: {sf, opc, 01010, 000, rm, 000000, rn, rd}, where opc = 00 AND, 01 ORR, 10 EOR, 11 ANDS
  - op3: {sf, 1, fn[0], 100101, hw, imm[15:0], rd}
  - op4: {fn[0], 00101, imm[25:0]}
  - op5: {sf, 011010, fn[0], imm[18:0], rd}
  - op6: {01010100, imm[18:0], 0, cond}
  - op7: 0xD61F0000 | rn<<5
  - op8: {11111000, 0, fn[0], 0, imm[8:0], 00, rn, rd}
  - op9: {sf, 0011011000, rm, 0, 11111, rn, rd}
- Illegal op (10–15): the request is accepted (handshake completes), nothing is written, and err is set.
- One output register holds the encoded word and its address.
- An accepted request (req_valid & req_ready) loads the output register, and wr_valid is set on the next edge.
- A write completes on wr_valid & wr_ready. On completion, wr_count increments and the address pointer advances by 4, wrapping modulo 2^ADDR_W.
- wr_addr is captured from the address pointer at request acceptance. The pointer advances at write completion.
- While wr_valid && !wr_ready, wr_data and wr_addr hold stable.
- addr_load sets the pointer to {addr_in[ADDR_W-1:2], 00}. The load has priority over the +4 advance when both occur in the same cycle. A word already held in the output register keeps its captured address.
- Reset (asynchronous, mid-write allowed): wr_valid=0, wr_data=0, wr_addr=0, pointer=0, wr_count=0, err=0. A word pending at reset is dropped.

## Timing
- Latency: 1 cycle from request acceptance to wr_valid.
- req_ready = !wr_valid || wr_ready. This is a combinational pass-through, so full throughput (1 word/cycle) is sustained while wr_ready stays high.
- Simultaneous write completion and new acceptance: the output register reloads in the same edge and wr_valid stays 1.
- Back-to-back words after a pointer load use base, base+4, base+8, …
- err rises on the edge after the rejected request is accepted and stays set until reset.

## Configuration
- ENC_RANGE_CHECK_EN
  - Defined:
    - A signed immediate must equal the sign extension of its field width.
    - An unsigned immediate must have all bits above its field width zero. Field widths: 12 for op0, 16 for op3, 26 for op4, 19 for ops 5 and 6, 9 for op8.
    - A nonzero hw with sf=0 is rejected if hw[1]=1.
    - A failing request is accepted, not written, and sets err.
  - Undefined: out-of-range immediates are silently truncated to the field width. Only illegal ops set err.

## Test plan
- Reset, then ADD X1,X2,#5 (op0, sf=1, fn=00, rd=1, rn=2, imm=5) -> wr_data=0x91001441, wr_addr=0, wr_count=1 after the handshake.
- addr_load with addr_in=0x1003, then BR X30 (op7, rn=30) -> wr_addr=0x1000, wr_data=0xD61F03C0.
- LDUR X3,[X4,#8] (op8, fn=01, rd=3, rn=4, imm=8), then B.NE imm=-1 (op6, cond=1), with wr_ready held low 3 cycles -> words hold stable; then 0xF8408083 at addr A and 0x54FFFFE1 at A+4.
- MUL X0,X1,X2 (op9, sf=1) streamed back-to-back with wr_ready=1 -> wr_data=0x9B027C20, one word per cycle, req_ready never drops.
- op=12 -> no write occurs, wr_count unchanged, err=1. With ENC_RANGE_CHECK_EN defined, op0 with imm=0x1000 -> err=1 and no write; without the macro -> word written with imm field 0.
- Assert reset while wr_valid=1 and wr_ready=0 -> wr_valid=0, wr_count=0, and the pointer is 0 on the next accepted request.
